// File: rtl/wrr_burst_arbiter_pkg.sv
// Shared types and bit-manipulation helpers for the weighted round-robin burst arbiter.
// Helpers work on a fixed MAX_REQ-wide vector; callers zero-extend in and truncate out.
package wrr_pkg;

  localparam int MAX_REQ = 32;

  typedef logic [MAX_REQ-1:0] req_vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // All bits strictly above the set bit of a one-hot vector; the top bit yields zero (wrap).
  function automatic req_vec_t therm_above(input req_vec_t onehot);
    return ~((onehot << 1) - req_vec_t'(1));
  endfunction

  function automatic req_vec_t lowest_set(input req_vec_t v);
    return v & (~v + req_vec_t'(1));
  endfunction

endpackage

// File: rtl/wrr_burst_arbiter_if.sv
// Requester/sink handshake bundle for wrr_burst_arbiter.
// The slave modport is the arbiter side; the master modport drives requests and sink ready.
interface wrr_burst_arbiter_if #(
  parameter int N_REQ    = 8,
  parameter int WEIGHT_W = 4
);
  logic [N_REQ-1:0]          req_i;
  logic [N_REQ*WEIGHT_W-1:0] weight_i;
  logic [N_REQ-1:0]          gnt_o;
  logic                      gnt_valid_o;
  logic                      gnt_rdy_i;
  logic                      last_o;
  logic                      busy_o;

  modport master (
    output req_i, weight_i, gnt_rdy_i,
    input  gnt_o, gnt_valid_o, last_o, busy_o
  );

  modport slave (
    input  req_i, weight_i, gnt_rdy_i,
    output gnt_o, gnt_valid_o, last_o, busy_o
  );
endinterface

// File: rtl/wrr_burst_arbiter_rr_pick.sv
// Combinational round-robin winner select: lowest requester above the priority
// pointer if any, otherwise the lowest requester overall.
module rr_pick
  import wrr_pkg::*;
#(
  parameter int N_REQ = 8
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] hptr,
  output logic [N_REQ-1:0] winner
);

  logic [N_REQ-1:0] masked;

  assign masked = req & hptr;
  assign winner = (|masked) ? N_REQ'(lowest_set(req_vec_t'(masked)))
                            : N_REQ'(lowest_set(req_vec_t'(req)));

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter: the winner owns the sink for up to its weight in
// beats, then the grant rotates past it after one idle cycle.
module wrr_burst_arbiter
  import wrr_pkg::*;
#(
  parameter int N_REQ    = 8,
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  wrr_burst_arbiter_if.slave  bus
);

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0]    hptr_q, hptr_d;
  logic [N_REQ-1:0]    winner;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WEIGHT_W-1:0] win_weight;
  logic                owner_req;
  logic                beat_ok;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req_i),
    .hptr   (hptr_q),
    .winner (winner)
  );

  always_comb begin
    win_weight = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) win_weight = bus.weight_i[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  assign owner_req = |(bus.req_i & owner_q);
  assign beat_ok   = owner_req & bus.gnt_rdy_i;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    hptr_d   = hptr_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_i) begin
          state_d  = BURST;
          owner_d  = winner;
          credit_d = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
        end
      end
      BURST: begin
        // A dropped request releases without consuming a beat.
        if (!owner_req || (beat_ok && credit_q == WEIGHT_W'(1))) begin
          state_d  = IDLE;
          owner_d  = '0;
          credit_d = '0;
          hptr_d   = N_REQ'(therm_above(req_vec_t'(owner_q)));
        end else if (beat_ok) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      credit_q <= '0;
      hptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      hptr_q   <= hptr_d;
    end
  end

  assign bus.gnt_o       = owner_q;
  assign bus.busy_o      = (state_q == BURST);
  assign bus.gnt_valid_o = (state_q == BURST) & owner_req;
  assign bus.last_o      = bus.gnt_valid_o & (credit_q == WEIGHT_W'(1));

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Self-checking bench for wrr_burst_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against a circular-search reference model.
module tb_wrr_burst_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;

  wrr_burst_arbiter_if #(.N_REQ(N), .WEIGHT_W(W)) bus ();

  wrr_burst_arbiter #(.N_REQ(N), .WEIGHT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wts[N];

  // reference model: burst owner, remaining credit, next search start
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_credit = 0;
  int m_ptr   = 0;
  int m_limit = 0;

  logic [N-1:0] prev_gnt = '0;
  int beats = 0;
  int cur_limit = 0;
  int rec_owner[$];
  int rec_beats[$];
  int fair[N][N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic clear_track();
    rec_owner.delete();
    rec_beats.delete();
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) fair[i][j] = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic rdy, input logic rst);
    bit found;
    if (rst) begin
      m_busy = 1'b0; m_credit = 0; m_ptr = 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int c = (m_ptr + k) % N;
          if (!found && req[c]) begin found = 1'b1; m_owner = c; end
        end
        m_credit = (wts[m_owner] > 0) ? wts[m_owner] : 1;
        m_limit  = m_credit;
        m_busy   = 1'b1;
      end
    end else if (!req[m_owner] || (rdy && m_credit == 1)) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N;
    end else if (rdy) begin
      m_credit--;
    end
  endtask

  task automatic cycle(input logic [N-1:0] req, input logic rdy, input logic rst);
    logic [N-1:0] e_gnt;
    logic e_valid, e_last;
    @(negedge clk);
    bus.req_i = req;
    bus.gnt_rdy_i = rdy;
    reset = rst;
    for (int i = 0; i < N; i++) bus.weight_i[i*W +: W] = W'(wts[i]);
    #1;
    e_gnt = '0;
    if (m_busy) e_gnt[m_owner] = 1'b1;
    e_valid = m_busy && req[m_owner];
    e_last  = e_valid && (m_credit == 1);
    chk("gnt", bus.gnt_o, e_gnt);
    chk("gnt_valid", bus.gnt_valid_o, e_valid);
    chk("last", bus.last_o, e_last);
    chk("busy", bus.busy_o, m_busy);
    chk("onehot0", $onehot0(bus.gnt_o), 1);
    if (prev_gnt != '0 && bus.gnt_o != prev_gnt) begin
      rec_owner.push_back(idx_of(prev_gnt));
      rec_beats.push_back(beats);
      chk("burst_len_bound", beats <= cur_limit, 1);
    end
    for (int i = 0; i < N; i++)
      if (!req[i]) for (int j = 0; j < N; j++) fair[i][j] = 0;
    if (bus.gnt_o != '0 && bus.gnt_o != prev_gnt) begin
      int g = idx_of(bus.gnt_o);
      beats = 0;
      cur_limit = m_limit;
      for (int i = 0; i < N; i++) begin
        if (i != g && req[i]) begin
          fair[i][g]++;
          chk("fairness", fair[i][g] <= 1, 1);
        end
      end
      for (int j = 0; j < N; j++) fair[g][j] = 0;
    end
    if (bus.gnt_valid_o && rdy) beats++;
    prev_gnt = bus.gnt_o;
    model_step(req, rdy, rst);
  endtask

  task automatic do_reset();
    cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0);
    clear_track();
  endtask

  initial begin
    logic [N-1:0] rq;
    reset = 1'b1;
    bus.req_i = '0;
    bus.gnt_rdy_i = 1'b0;
    bus.weight_i = '0;
    for (int i = 0; i < N; i++) wts[i] = 1;
    repeat (2) @(posedge clk);
    cycle('0, 1'b0, 1'b0);

    // reset mid-burst abandons the burst; requester 1 then regains full credit
    wts[1] = 3;
    do_reset();
    cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0010, 1'b0, 1'b1);
    chk("rst_gnt_next", 32'(bus.gnt_o == 4'b0010), 1);
    cycle(4'b0010, 1'b1, 1'b0);
    chk("rst_gnt_cleared", bus.gnt_o, 0);
    repeat (3) cycle(4'b0010, 1'b1, 1'b0);
    cycle('0, 1'b1, 1'b0);
    chk("rst_nrec", rec_owner.size(), 2);
    if (rec_owner.size() >= 2) begin
      chk("rst_abandon_beats", rec_beats[0], 1);
      chk("rst_regrant_owner", rec_owner[1], 1);
      chk("rst_regrant_beats", rec_beats[1], 3);
    end

    // weighted rotation
    wts[0] = 1; wts[1] = 2; wts[2] = 3; wts[3] = 1;
    do_reset();
    repeat (14) cycle(4'b1111, 1'b1, 1'b0);
    repeat (2) cycle('0, 1'b1, 1'b0);
    chk("rot_nrec", rec_owner.size() >= 5, 1);
    if (rec_owner.size() >= 5) begin
      int eo[5] = '{0, 1, 2, 3, 0};
      int eb[5] = '{1, 2, 3, 1, 1};
      for (int k = 0; k < 5; k++) begin
        chk("rot_owner", rec_owner[k], eo[k]);
        chk("rot_beats", rec_beats[k], eb[k]);
      end
    end

    // backpressure holds owner and credit
    wts[2] = 2;
    do_reset();
    cycle(4'b0100, 1'b0, 1'b0);
    repeat (5) cycle(4'b0100, 1'b0, 1'b0);
    chk("bp_hold", bus.gnt_o, 4'b0100);
    repeat (2) cycle(4'b0100, 1'b1, 1'b0);
    repeat (2) cycle('0, 1'b1, 1'b0);
    chk("bp_nrec", rec_owner.size(), 1);
    if (rec_owner.size() >= 1) chk("bp_beats", rec_beats[0], 2);

    // early drop releases and moves priority past requester 0
    wts[0] = 5;
    do_reset();
    repeat (3) cycle(4'b0001, 1'b1, 1'b0);
    cycle('0, 1'b1, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0);
    chk("drop_idle", bus.gnt_o, 0);
    cycle(4'b1111, 1'b1, 1'b0);
    chk("drop_next_owner", bus.gnt_o, 4'b0010);
    repeat (2) cycle('0, 1'b1, 1'b0);
    if (rec_owner.size() >= 1) chk("drop_beats", rec_beats[0], 2);

    // wrap after top requester, and zero weight behaves as one
    wts[3] = 1; wts[0] = 0;
    do_reset();
    cycle(4'b1000, 1'b1, 1'b0);
    cycle(4'b1001, 1'b1, 1'b0);
    cycle(4'b1001, 1'b1, 1'b0);
    cycle(4'b1001, 1'b1, 1'b0);
    chk("wrap_owner", bus.gnt_o, 4'b0001);
    chk("zero_w_last", bus.last_o, 1);
    repeat (2) cycle('0, 1'b1, 1'b0);
    chk("wrap_nrec", rec_owner.size(), 2);
    if (rec_owner.size() >= 2) chk("zero_w_beats", rec_beats[1], 1);

    // randomized run
    do_reset();
    rq = '0;
    for (int n = 0; n < 10000; n++) begin
      if (n % 500 == 0) for (int i = 0; i < N; i++) wts[i] = $urandom_range(0, 15);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
      cycle(rq, ($urandom_range(0, 3) != 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
